// File: rtl/mem_bist_ctrl_if.sv
// Memory-side bus between the BIST controller and the memory under test.
// The controller owns we/addr/write; the memory returns read data.
interface mem_bist_ctrl_if #(
    parameter int N = 8
) ();
    logic         mem_we;
    logic [N-1:0] mem_addr;
    logic [N-1:0] mem_write;
    logic [N-1:0] mem_read;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_write,
        input  mem_read
    );

    modport slave (
        input  mem_we,
        input  mem_addr,
        input  mem_write,
        output mem_read
    );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes pattern(a) to every address of a 2^N-word
// memory, then reads each word back (one cycle of read latency allowed) and
// counts mismatches, recording the first failing address.
// Optional build macro MEM_BIST_INVERT_EN adds a second write/read pass with
// the inverted pattern ~a; results accumulate across both passes.
module mem_bist_ctrl #(
    parameter int N = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    mem_bist_ctrl_if.master        mem,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N-1:0]           fail_addr,
    output logic [N-1:0]           err_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        RD_ADDR  = 3'd2,
        RD_CHECK = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [N-1:0] LAST = '1;
    localparam logic [N-1:0] ONE  = {{(N-1){1'b0}}, 1'b1};

    state_t       state, state_nx;
    logic [N-1:0] cnt, cnt_nx;
    logic         inv, inv_nx;
    logic [N-1:0] err_nx, fail_nx;
    logic         pass_nx;
    logic         mismatch;
    logic [N-1:0] wr_last;

    // Test pattern for an address; the inverted pass writes the complement.
    function automatic logic [N-1:0] pattern(input logic [N-1:0] a, input logic invert);
        return invert ? ~a : a;
    endfunction

    // Error counter increment that sticks at all-ones.
    function automatic logic [N-1:0] sat_inc(input logic [N-1:0] v);
        return (v == LAST) ? v : v + ONE;
    endfunction

    // Next-state, address counter and result bookkeeping.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        inv_nx   = inv;
        err_nx   = err_count;
        fail_nx  = fail_addr;
        pass_nx  = pass;
        mismatch = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = WRITE;
                    cnt_nx   = '0;
                    inv_nx   = 1'b0;
                    err_nx   = '0;
                    fail_nx  = '0;
                end
            end
            WRITE: begin
                if (cnt == LAST) begin
                    cnt_nx   = '0;
                    state_nx = RD_ADDR;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            RD_ADDR: begin
                state_nx = RD_CHECK;
            end
            RD_CHECK: begin
                mismatch = (mem.mem_read != pattern(cnt, inv));
                if (mismatch) begin
                    // err_count is still zero only before the first mismatch of the run
                    if (err_count == '0) begin
                        fail_nx = cnt;
                    end
                    err_nx = sat_inc(err_count);
                end
                if (cnt == LAST) begin
`ifdef MEM_BIST_INVERT_EN
                    if (!inv) begin
                        inv_nx   = 1'b1;
                        cnt_nx   = '0;
                        state_nx = WRITE;
                    end else begin
                        state_nx = DONE;
                        pass_nx  = (err_nx == '0);
                    end
`else
                    state_nx = DONE;
                    pass_nx  = (err_nx == '0);
`endif
                end else begin
                    cnt_nx   = cnt + ONE;
                    state_nx = RD_ADDR;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State, counter and result registers; reset abandons any run in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            inv       <= 1'b0;
            err_count <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            inv       <= inv_nx;
            err_count <= err_nx;
            fail_addr <= fail_nx;
            pass      <= pass_nx;
        end
    end

    // Remember the last driven write data so it is held outside WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_last <= '0;
        end else begin
            wr_last <= mem.mem_write;
        end
    end

    assign mem.mem_we    = (state == WRITE);
    assign mem.mem_addr  = cnt;
    assign mem.mem_write = (state == WRITE) ? pattern(cnt, inv) : wr_last;
    assign busy          = (state == WRITE) || (state == RD_ADDR) || (state == RD_CHECK);
    assign done          = (state == DONE);

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 SHALL have parameter N, default 8, which sets the address width and the data width of the driven memory (2^N words).
REQ-002 SHALL have clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have start  input  1  level-sampled request that begins a test run when idle.
REQ-005 SHALL have mem_we  output  1  write enable, driven to the memory's we port.
REQ-006 SHALL have mem_addr  output  N  address, driven to the memory's addr port.
REQ-007 SHALL have mem_write  output  N  write data, driven to the memory's write port.
REQ-008 SHALL have mem_read  input  N  read data, taken from the memory's read port.
REQ-009 SHALL have busy  output  1  high while a run is in progress.
REQ-010 SHALL have done  output  1  one-cycle pulse at the end of a run.
REQ-011 SHALL have pass  output  1  result of the last completed run (1 = no mismatches).
REQ-012 SHALL have fail_addr  output  N  address of the first mismatch in the last run.
REQ-013 SHALL have err_count  output  N  mismatch count for the last run, saturating at 2^N-1.

Function
REQ-014 SHALL implement the states IDLE, WRITE, RD_ADDR, RD_CHECK and DONE.
REQ-015 In IDLE, SHALL go to WRITE on the first rising edge where start=1, clearing err_count, fail_addr and the internal address counter to 0 on that edge.
REQ-016 In WRITE, SHALL drive mem_we=1, mem_addr=cnt and mem_write=pattern(cnt) for one cycle per address, incrementing cnt each cycle; after cnt=2^N-1 it SHALL wrap cnt to 0 and go to RD_ADDR.
REQ-017 pattern(a) SHALL equal a in the first pass.
REQ-018 In RD_ADDR, SHALL drive mem_we=0 and mem_addr=cnt, then go to RD_CHECK; mem_addr SHALL be held at cnt during RD_CHECK.
REQ-019 In RD_CHECK, SHALL compare mem_read with pattern(cnt), giving a 1-cycle read latency allowance.
REQ-020 On the first mismatch of a run, SHALL latch fail_addr=cnt; later mismatches SHALL NOT change fail_addr.
REQ-021 On every mismatch, SHALL increment err_count unless err_count already equals 2^N-1.
REQ-022 From RD_CHECK with cnt<2^N-1, SHALL increment cnt and go to RD_ADDR; with cnt=2^N-1, it SHALL go to DONE (or to the next pass, see REQ-030).
REQ-023 In DONE, SHALL assert done=1 for exactly one cycle, set pass=(err_count==0 including the final compare), then return to IDLE.
REQ-024 busy SHALL be 1 in WRITE, RD_ADDR and RD_CHECK, and 0 in IDLE and DONE.
REQ-025 SHALL ignore start when not in IDLE; start held high in IDLE after DONE SHALL begin a new run.
REQ-026 Outside WRITE, mem_we SHALL be 0, and mem_write SHALL hold its last value.
REQ-027 Single-pass run length SHALL be 3*2^N+1 cycles from the start-sampling edge to the done pulse (769 cycles for N=8).
REQ-028 pass, fail_addr and err_count SHALL hold their values until the next run starts.

Reset
REQ-029 rst=1 SHALL immediately force state=IDLE, cnt=0, mem_we=0, mem_addr=0, mem_write=0, busy=0, done=0, pass=0, fail_addr=0 and err_count=0, including mid-run; the run is abandoned and no done pulse is issued.

Configuration
REQ-030 Macro MEM_BIST_INVERT_EN: when defined, after the first read pass SHALL run a second WRITE/read pass with pattern(a)=~a, continuing to accumulate err_count and keep the first fail_addr, making the run 6*2^N+1 cycles; when undefined, SHALL run a single pass only.

Verification
REQ-031 Fault-free memory, N=8, start pulsed 1 cycle -> writes of 0x00..0xFF observed; done at cycle 769; pass=1, err_count=0, fail_addr=0.
REQ-032 Bench memory model with bit 3 stuck-at-0 at address 0x2A -> pass=0, fail_addr=0x2A, err_count=1.
REQ-033 Mismatches injected at addresses 0x10 and 0x80 -> fail_addr=0x10, err_count=2; every address mismatching -> err_count saturates at 0xFF.
REQ-034 rst asserted at cycle 100 of a run -> all outputs 0 in the same cycle, no done pulse; a subsequent start completes normally with pass=1.
REQ-035 start held high throughout a run -> no restart while busy; a new run begins on the edge after DONE; with MEM_BIST_INVERT_EN defined, done occurs at cycle 1537 and the second pass writes 0xFF..0x00 at addresses 0x00..0xFF.
